// File: rtl/amdc_analog_axi_regs_if.sv
// AXI4-Lite bus bundle between the interconnect master and the amdc_analog register file.
interface amdc_analog_axi_regs_if #(
  parameter int unsigned ADDR_WIDTH = 4
);
  logic [ADDR_WIDTH-1:0] awaddr;
  logic [2:0]            awprot;
  logic                  awvalid;
  logic                  awready;
  logic [31:0]           wdata;
  logic [3:0]            wstrb;
  logic                  wvalid;
  logic                  wready;
  logic [1:0]            bresp;
  logic                  bvalid;
  logic                  bready;
  logic [ADDR_WIDTH-1:0] araddr;
  logic [2:0]            arprot;
  logic                  arvalid;
  logic                  arready;
  logic [31:0]           rdata;
  logic [1:0]            rresp;
  logic                  rvalid;
  logic                  rready;

  modport master (
    output awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
    output araddr, arprot, arvalid, rready,
    input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

  modport slave (
    input  awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
    input  araddr, arprot, arvalid, rready,
    output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );
endinterface

// File: rtl/amdc_analog_axi_regs.sv
// AXI4-Lite responder holding NUM_REGS 32-bit RW registers for the amdc_analog capture logic.
// Write and read channels run independent FSMs; all bus outputs are registered.
module amdc_analog_axi_regs #(
  parameter int unsigned ADDR_WIDTH = 4,
  parameter int unsigned NUM_REGS   = 4
) (
  input  logic                    aclk,
  input  logic                    aresetn,
  amdc_analog_axi_regs_if.slave   s_axi,
  output logic [32*NUM_REGS-1:0]  reg_out,
  output logic [NUM_REGS-1:0]     reg_wr_pulse
);
  localparam int unsigned DATA_W = 32;
  localparam int unsigned STRB_W = DATA_W / 8;
  localparam int unsigned IDX_W  = ADDR_WIDTH - 2;
  localparam logic [1:0]  RESP_OKAY   = 2'b00;
  localparam logic [1:0]  RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {W_IDLE, W_HAVE_AW, W_HAVE_W, W_RESP} w_state_e;
  typedef enum logic       {R_IDLE, R_DATA} r_state_e;

  w_state_e                 w_state_q, w_state_d;
  r_state_e                 r_state_q, r_state_d;
  logic                     awready_q, wready_q, bvalid_q, arready_q, rvalid_q;
  logic                     awready_d, wready_d, bvalid_d, arready_d, rvalid_d;
  logic [1:0]               bresp_q, rresp_q;
  logic [DATA_W-1:0]        rdata_q;
  logic [IDX_W-1:0]         aw_idx_q;
  logic [DATA_W-1:0]        wdata_q;
  logic [STRB_W-1:0]        wstrb_q;
  logic [DATA_W*NUM_REGS-1:0] regs_q;
  logic [NUM_REGS-1:0]      pulse_q;

  logic                     aw_hs_c, w_hs_c, b_hs_c, ar_hs_c, r_hs_c, commit_c;
  logic [IDX_W-1:0]         cmt_idx_c, ar_idx_c;
  logic [DATA_W-1:0]        cmt_data_c, rd_mux_c;
  logic [STRB_W-1:0]        cmt_strb_c;
  logic                     cmt_ok_c, ar_ok_c;
  logic                     unused_c;

  assign aw_hs_c = s_axi.awvalid & awready_q;
  assign w_hs_c  = s_axi.wvalid & wready_q;
  assign b_hs_c  = bvalid_q & s_axi.bready;
  assign ar_hs_c = s_axi.arvalid & arready_q;
  assign r_hs_c  = rvalid_q & s_axi.rready;

  // Whichever half arrives on the committing edge is taken live, the other from its latch.
  assign cmt_idx_c  = aw_hs_c ? s_axi.awaddr[ADDR_WIDTH-1:2] : aw_idx_q;
  assign cmt_data_c = w_hs_c ? s_axi.wdata : wdata_q;
  assign cmt_strb_c = w_hs_c ? s_axi.wstrb : wstrb_q;
  assign cmt_ok_c   = 32'(cmt_idx_c) < NUM_REGS;
  assign ar_idx_c   = s_axi.araddr[ADDR_WIDTH-1:2];
  assign ar_ok_c    = 32'(ar_idx_c) < NUM_REGS;

  assign unused_c = ^{s_axi.awprot, s_axi.arprot, s_axi.awaddr[1:0], s_axi.araddr[1:0]};

  // Write FSM next state and next-cycle ready/valid values.
  always_comb begin
    w_state_d = w_state_q;
    commit_c  = 1'b0;
    case (w_state_q)
      W_IDLE: begin
        if (aw_hs_c && w_hs_c) begin
          commit_c  = 1'b1;
          w_state_d = W_RESP;
        end else if (aw_hs_c) begin
          w_state_d = W_HAVE_AW;
        end else if (w_hs_c) begin
          w_state_d = W_HAVE_W;
        end
      end
      W_HAVE_AW: if (w_hs_c) begin
        commit_c  = 1'b1;
        w_state_d = W_RESP;
      end
      W_HAVE_W: if (aw_hs_c) begin
        commit_c  = 1'b1;
        w_state_d = W_RESP;
      end
      W_RESP: if (b_hs_c) w_state_d = W_IDLE;
      default: w_state_d = W_IDLE;
    endcase
    awready_d = (w_state_d == W_IDLE) || (w_state_d == W_HAVE_W);
    wready_d  = (w_state_d == W_IDLE) || (w_state_d == W_HAVE_AW);
    bvalid_d  = (w_state_d == W_RESP);
  end

  // Read FSM next state and next-cycle ready/valid values.
  always_comb begin
    r_state_d = r_state_q;
    case (r_state_q)
      R_IDLE:  if (ar_hs_c) r_state_d = R_DATA;
      R_DATA:  if (r_hs_c)  r_state_d = R_IDLE;
      default: r_state_d = R_IDLE;
    endcase
    arready_d = (r_state_d == R_IDLE);
    rvalid_d  = (r_state_d == R_DATA);
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      w_state_q <= W_IDLE;
      r_state_q <= R_IDLE;
      awready_q <= 1'b0;
      wready_q  <= 1'b0;
      bvalid_q  <= 1'b0;
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
    end else begin
      w_state_q <= w_state_d;
      r_state_q <= r_state_d;
      awready_q <= awready_d;
      wready_q  <= wready_d;
      bvalid_q  <= bvalid_d;
      arready_q <= arready_d;
      rvalid_q  <= rvalid_d;
    end
  end

  // Write datapath: channel latches, byte-lane register update, response and pulse.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      aw_idx_q <= '0;
      wdata_q  <= '0;
      wstrb_q  <= '0;
      regs_q   <= '0;
      pulse_q  <= '0;
      bresp_q  <= RESP_OKAY;
    end else begin
      pulse_q <= '0;
      if (aw_hs_c) aw_idx_q <= s_axi.awaddr[ADDR_WIDTH-1:2];
      if (w_hs_c) begin
        wdata_q <= s_axi.wdata;
        wstrb_q <= s_axi.wstrb;
      end
      if (commit_c) begin
        bresp_q <= cmt_ok_c ? RESP_OKAY : RESP_SLVERR;
        for (int unsigned k = 0; k < NUM_REGS; k++) begin
          if (cmt_idx_c == IDX_W'(k)) begin
            for (int unsigned b = 0; b < STRB_W; b++) begin
              if (cmt_strb_c[b]) regs_q[DATA_W*k + 8*b +: 8] <= cmt_data_c[8*b +: 8];
            end
            pulse_q[k] <= |cmt_strb_c;
          end
        end
      end
    end
  end

  // Out-of-range indices match no register and read as zero.
  always_comb begin
    rd_mux_c = '0;
    for (int unsigned k = 0; k < NUM_REGS; k++) begin
      if (ar_idx_c == IDX_W'(k)) rd_mux_c = regs_q[DATA_W*k +: DATA_W];
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      rdata_q <= '0;
      rresp_q <= RESP_OKAY;
    end else if (ar_hs_c) begin
      rdata_q <= rd_mux_c;
      rresp_q <= ar_ok_c ? RESP_OKAY : RESP_SLVERR;
    end
  end

  assign s_axi.awready = awready_q;
  assign s_axi.wready  = wready_q;
  assign s_axi.bvalid  = bvalid_q;
  assign s_axi.bresp   = bresp_q;
  assign s_axi.arready = arready_q;
  assign s_axi.rvalid  = rvalid_q;
  assign s_axi.rdata   = rdata_q;
  assign s_axi.rresp   = rresp_q;
  assign reg_out       = regs_q;
  assign reg_wr_pulse  = pulse_q;
endmodule

// File: tb/tb_amdc_analog_axi_regs.sv
// Directed bench for amdc_analog_axi_regs with ADDR_WIDTH=5, NUM_REGS=4.
module tb_amdc_analog_axi_regs;
  logic         aclk;
  logic         aresetn;
  logic [127:0] reg_out;
  logic [3:0]   reg_wr_pulse;
  int           tests;
  int           fails;
  int           pulse_cnt [4];

  amdc_analog_axi_regs_if #(.ADDR_WIDTH(5)) axi ();

  amdc_analog_axi_regs #(.ADDR_WIDTH(5), .NUM_REGS(4)) dut (
    .aclk         (aclk),
    .aresetn      (aresetn),
    .s_axi        (axi),
    .reg_out      (reg_out),
    .reg_wr_pulse (reg_wr_pulse)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  always @(negedge aclk) begin
    for (int k = 0; k < 4; k++) if (reg_wr_pulse[k]) pulse_cnt[k] = pulse_cnt[k] + 1;
  end

  task automatic tick;
    @(posedge aclk);
    #1;
  endtask

  task automatic axi_write(input logic [4:0] addr, input logic [31:0] data,
                           input logic [3:0] strb, output logic [1:0] resp);
    bit aw_done, w_done, aw_go, w_go;
    int n;
    axi.awaddr = addr; axi.wdata = data; axi.wstrb = strb;
    axi.awvalid = 1'b1; axi.wvalid = 1'b1;
    aw_done = 0; w_done = 0; n = 0;
    while (!(aw_done && w_done) && n < 50) begin
      aw_go = axi.awvalid && axi.awready;
      w_go  = axi.wvalid && axi.wready;
      tick(); n++;
      if (aw_go) begin axi.awvalid = 1'b0; aw_done = 1; end
      if (w_go)  begin axi.wvalid = 1'b0;  w_done = 1;  end
    end
    axi.awvalid = 1'b0; axi.wvalid = 1'b0;
    axi.bready = 1'b1; n = 0;
    while (!axi.bvalid && n < 50) begin tick(); n++; end
    if (!axi.bvalid) begin
      tests++; fails++;
      $display("FAIL write_timeout addr=%h: bvalid got %b, required 1", addr, axi.bvalid);
    end
    resp = axi.bresp;
    tick();
    axi.bready = 1'b0;
  endtask

  task automatic axi_read(input logic [4:0] addr, output logic [31:0] data, output logic [1:0] resp);
    bit go;
    int n;
    axi.araddr = addr; axi.arvalid = 1'b1; n = 0; go = 0;
    while (!go && n < 50) begin
      go = axi.arready;
      tick(); n++;
    end
    axi.arvalid = 1'b0;
    axi.rready = 1'b1; n = 0;
    while (!axi.rvalid && n < 50) begin tick(); n++; end
    if (!axi.rvalid) begin
      tests++; fails++;
      $display("FAIL read_timeout addr=%h: rvalid got %b, required 1", addr, axi.rvalid);
    end
    data = axi.rdata; resp = axi.rresp;
    tick();
    axi.rready = 1'b0;
  endtask

  task automatic test_reset;
    #23;
    tests++;
    if ({axi.awready, axi.wready, axi.arready, axi.bvalid, axi.rvalid} !== 5'b0) begin
      fails++; $display("FAIL reset_hs: got %b, required 00000",
                        {axi.awready, axi.wready, axi.arready, axi.bvalid, axi.rvalid});
    end
    tests++;
    if ({axi.rdata, axi.bresp, axi.rresp, reg_wr_pulse} !== 40'h0) begin
      fails++; $display("FAIL reset_data: got %h, required 0", {axi.rdata, axi.bresp, axi.rresp, reg_wr_pulse});
    end
    tests++;
    if (reg_out !== 128'h0) begin fails++; $display("FAIL reset_regs: got %h, required 0", reg_out); end
    @(posedge aclk); #1; aresetn = 1'b1;
    tests++;
    if (axi.awready !== 1'b0) begin fails++; $display("FAIL ready_before_edge: got %b, required 0", axi.awready); end
    tick();
    tests++;
    if ({axi.awready, axi.wready, axi.arready} !== 3'b111) begin
      fails++; $display("FAIL ready_after_edge: got %b, required 111", {axi.awready, axi.wready, axi.arready});
    end
  endtask

  task automatic test_seq_rw;
    logic [1:0]  resp;
    logic [31:0] data;
    int          snap [4];
    snap = pulse_cnt;
    for (int i = 0; i < 4; i++) begin
      axi_write(5'(i*4), 32'(i+1), 4'hF, resp);
      tests++;
      if (resp !== 2'b00) begin fails++; $display("FAIL seq_bresp[%0d]: got %b, required 00", i, resp); end
    end
    for (int i = 0; i < 4; i++) begin
      axi_read(5'(i*4), data, resp);
      tests++;
      if ({data, resp} !== {32'(i+1), 2'b00}) begin
        fails++; $display("FAIL seq_read[%0d]: got %h/%b, required %h/00", i, data, resp, 32'(i+1));
      end
      tests++;
      if (pulse_cnt[i] - snap[i] !== 1) begin
        fails++; $display("FAIL seq_pulse[%0d]: got %0d pulses, required 1", i, pulse_cnt[i] - snap[i]);
      end
    end
    tests++;
    if (reg_out !== 128'h00000004_00000003_00000002_00000001) begin
      fails++; $display("FAIL seq_reg_out: got %h, required 00000004000000030000000200000001", reg_out);
    end
  endtask

  task automatic test_strobes;
    logic [1:0]  resp;
    logic [31:0] data;
    int          snap;
    axi_write(5'h04, 32'hAABBCCDD, 4'hF, resp);
    axi_write(5'h04, 32'h11223344, 4'h5, resp);
    axi_read(5'h04, data, resp);
    tests++;
    if (data !== 32'hAA22CC44) begin fails++; $display("FAIL strobe_merge: got %h, required aa22cc44", data); end
    snap = pulse_cnt[1];
    axi_write(5'h04, 32'hFFFFFFFF, 4'h0, resp);
    tests++;
    if (resp !== 2'b00) begin fails++; $display("FAIL strobe_zero_bresp: got %b, required 00", resp); end
    tests++;
    if (pulse_cnt[1] != snap || reg_out[63:32] !== 32'hAA22CC44) begin
      fails++; $display("FAIL strobe_zero_effect: got %h pulses=%0d, required aa22cc44 pulses=0",
                        reg_out[63:32], pulse_cnt[1] - snap);
    end
  endtask

  task automatic test_skew;
    // AW three cycles ahead of W
    axi.awaddr = 5'h08; axi.awvalid = 1'b1; tick(); axi.awvalid = 1'b0;
    tests++;
    if ({axi.awready, axi.wready} !== 2'b01) begin
      fails++; $display("FAIL skew_have_aw: got %b, required 01", {axi.awready, axi.wready});
    end
    tick(); tick();
    axi.wdata = 32'hDEADBEEF; axi.wstrb = 4'hF; axi.wvalid = 1'b1;
    tests++;
    if (axi.bvalid !== 1'b0) begin fails++; $display("FAIL skew_aw_early_b: got %b, required 0", axi.bvalid); end
    tick(); axi.wvalid = 1'b0;
    tests++;
    if ({axi.bvalid, axi.bresp, reg_wr_pulse, reg_out[95:64]} !== {1'b1, 2'b00, 4'b0100, 32'hDEADBEEF}) begin
      fails++; $display("FAIL skew_aw_first: got b=%b resp=%b pulse=%b reg=%h, required 1/00/0100/deadbeef",
                        axi.bvalid, axi.bresp, reg_wr_pulse, reg_out[95:64]);
    end
    axi.bready = 1'b1; tick(); axi.bready = 1'b0;
    tests++;
    if ({axi.bvalid, reg_wr_pulse, axi.awready} !== 6'b0_0000_1) begin
      fails++; $display("FAIL skew_b_done: got %b, required 000001", {axi.bvalid, reg_wr_pulse, axi.awready});
    end
    // W ahead of AW
    axi.wdata = 32'h0BADF00D; axi.wvalid = 1'b1; tick(); axi.wvalid = 1'b0;
    tests++;
    if ({axi.awready, axi.wready} !== 2'b10) begin
      fails++; $display("FAIL skew_have_w: got %b, required 10", {axi.awready, axi.wready});
    end
    tick();
    axi.awaddr = 5'h0C; axi.awvalid = 1'b1; tick(); axi.awvalid = 1'b0;
    tests++;
    if ({axi.bvalid, reg_out[127:96]} !== {1'b1, 32'h0BADF00D}) begin
      fails++; $display("FAIL skew_w_first: got %b/%h, required 1/0badf00d", axi.bvalid, reg_out[127:96]);
    end
    axi.bready = 1'b1; tick(); axi.bready = 1'b0;
    // Simultaneous AW and W
    axi.awaddr = 5'h00; axi.wdata = 32'hCAFE0001; axi.awvalid = 1'b1; axi.wvalid = 1'b1;
    tick(); axi.awvalid = 1'b0; axi.wvalid = 1'b0;
    tests++;
    if ({axi.bvalid, reg_out[31:0]} !== {1'b1, 32'hCAFE0001}) begin
      fails++; $display("FAIL skew_simul: got %b/%h, required 1/cafe0001", axi.bvalid, reg_out[31:0]);
    end
    axi.bready = 1'b1; tick(); axi.bready = 1'b0;
  endtask

  task automatic test_backpressure;
    axi.awaddr = 5'h04; axi.wdata = 32'h0000BEEF; axi.wstrb = 4'hF; axi.araddr = 5'h00;
    axi.awvalid = 1'b1; axi.wvalid = 1'b1; axi.arvalid = 1'b1;
    tick();
    axi.wvalid = 1'b0; axi.arvalid = 1'b0; axi.awaddr = 5'h08;
    for (int c = 0; c < 5; c++) begin
      tests++;
      if ({axi.bvalid, axi.rvalid, axi.awready, axi.wready, axi.arready, axi.rdata} !==
          {5'b11000, 32'hCAFE0001}) begin
        fails++; $display("FAIL bp_hold[%0d]: got %b rdata=%h, required 11000 rdata=cafe0001", c,
                          {axi.bvalid, axi.rvalid, axi.awready, axi.wready, axi.arready}, axi.rdata);
      end
      tick();
    end
    axi.bready = 1'b1; axi.rready = 1'b1; tick(); axi.bready = 1'b0; axi.rready = 1'b0;
    tests++;
    if ({axi.bvalid, axi.rvalid, axi.awready, axi.arready} !== 4'b0011) begin
      fails++; $display("FAIL bp_release: got %b, required 0011", {axi.bvalid, axi.rvalid, axi.awready, axi.arready});
    end
    tick(); axi.awvalid = 1'b0;
    tests++;
    if ({axi.awready, axi.wready} !== 2'b01) begin
      fails++; $display("FAIL bp_second_aw: got %b, required 01", {axi.awready, axi.wready});
    end
    axi.wdata = 32'h12340008; axi.wvalid = 1'b1; tick(); axi.wvalid = 1'b0;
    axi.bready = 1'b1; tick(); axi.bready = 1'b0;
    tests++;
    if (reg_out !== {32'h0BADF00D, 32'h12340008, 32'h0000BEEF, 32'hCAFE0001}) begin
      fails++; $display("FAIL bp_regs: got %h, required 0badf00d123400080000beefcafe0001", reg_out);
    end
  endtask

  task automatic test_out_of_range;
    logic [1:0]   resp;
    logic [31:0]  data;
    logic [127:0] regs_snap;
    int           snap [4];
    regs_snap = reg_out; snap = pulse_cnt;
    axi_write(5'h10, 32'h12345678, 4'hF, resp);
    tests++;
    if (resp !== 2'b10) begin fails++; $display("FAIL oor_bresp: got %b, required 10", resp); end
    tests++;
    if (reg_out !== regs_snap || pulse_cnt != snap) begin
      fails++; $display("FAIL oor_effect: got %h, required %h with no pulse", reg_out, regs_snap);
    end
    axi_read(5'h10, data, resp);
    tests++;
    if ({data, resp} !== {32'h0, 2'b10}) begin fails++; $display("FAIL oor_read10: got %h/%b, required 0/10", data, resp); end
    axi_read(5'h1C, data, resp);
    tests++;
    if ({data, resp} !== {32'h0, 2'b10}) begin fails++; $display("FAIL oor_read1c: got %h/%b, required 0/10", data, resp); end
    axi_read(5'h06, data, resp);
    tests++;
    if ({data, resp} !== {32'h0000BEEF, 2'b00}) begin
      fails++; $display("FAIL unaligned_read: got %h/%b, required 0000beef/00", data, resp);
    end
  endtask

  task automatic test_same_edge;
    axi.awaddr = 5'h00; axi.wdata = 32'h00000077; axi.wstrb = 4'hF; axi.araddr = 5'h00;
    axi.awvalid = 1'b1; axi.wvalid = 1'b1; axi.arvalid = 1'b1;
    tick();
    axi.awvalid = 1'b0; axi.wvalid = 1'b0; axi.arvalid = 1'b0;
    tests++;
    if ({axi.rvalid, axi.rdata, axi.bvalid, reg_out[31:0]} !== {1'b1, 32'hCAFE0001, 1'b1, 32'h77}) begin
      fails++; $display("FAIL same_edge: got r=%b %h b=%b reg=%h, required 1 cafe0001 1 00000077",
                        axi.rvalid, axi.rdata, axi.bvalid, reg_out[31:0]);
    end
    axi.bready = 1'b1; axi.rready = 1'b1; tick(); axi.bready = 1'b0; axi.rready = 1'b0;
  endtask

  task automatic test_reset_mid;
    logic [1:0]  resp;
    logic [31:0] data;
    axi_write(5'h00, 32'h55, 4'hF, resp);
    tests++;
    if (reg_out[31:0] !== 32'h55) begin fails++; $display("FAIL rst_pre_write: got %h, required 00000055", reg_out[31:0]); end
    axi.awaddr = 5'h04; axi.awvalid = 1'b1; tick(); axi.awvalid = 1'b0;
    aresetn = 1'b0; #1;
    tests++;
    if ({axi.awready, axi.wready, axi.arready, axi.bvalid, axi.rvalid, reg_wr_pulse, axi.rdata} !== 41'h0 ||
        reg_out !== 128'h0) begin
      fails++; $display("FAIL rst_mid_outputs: got hs=%b regs=%h, required 0",
                        {axi.awready, axi.wready, axi.arready, axi.bvalid, axi.rvalid}, reg_out);
    end
    repeat (2) @(posedge aclk);
    #1; aresetn = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tick();
      tests++;
      if (axi.bvalid !== 1'b0) begin fails++; $display("FAIL rst_no_bvalid[%0d]: got %b, required 0", c, axi.bvalid); end
    end
    axi_read(5'h00, data, resp);
    tests++;
    if ({data, resp} !== {32'h0, 2'b00}) begin fails++; $display("FAIL rst_readback: got %h/%b, required 0/00", data, resp); end
  endtask

  initial begin
    tests = 0; fails = 0;
    aresetn = 1'b0;
    axi.awaddr = '0; axi.awprot = '0; axi.awvalid = 1'b0;
    axi.wdata = '0; axi.wstrb = '0; axi.wvalid = 1'b0; axi.bready = 1'b0;
    axi.araddr = '0; axi.arprot = '0; axi.arvalid = 1'b0; axi.rready = 1'b0;
    test_reset();
    test_seq_rw();
    test_strobes();
    test_skew();
    test_backpressure();
    test_out_of_range();
    test_same_edge();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
